chacha_qr_seq: RTL and testbench

Multi-cycle, lane-parallel ChaCha quarter-round engine. It generalises the single-op add/xor-rotate ISE datapath to LANES independent 32-bit lanes. An internal sequencer runs the full 8-step quarter-round on registered a/b/c/d state. It sits beside the ChaCha ISE as a coprocessor-style unit behind a valid/ready handshake.

---
 rtl/chacha_pkg.sv | 31 +++
 rtl/chacha_qr_alu.sv | 26 ++
 rtl/chacha_qr_seq.sv | 145 ++++++++++++++
 tb/tb_chacha_qr_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared constants for the ChaCha quarter-round sequencer
// CHACHA_QR_FUSED_EN selects the fused add+xor-rotate datapath (narrower step counter).
package chacha_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef CHACHA_QR_FUSED_EN
  localparam int STEP_W = 2;
`else
  localparam int STEP_W = 3;
`endif

  localparam int ROT_W = 5;
  localparam logic [ROT_W-1:0] ROT_16 = 5'd16;
  localparam logic [ROT_W-1:0] ROT_12 = 5'd12;
  localparam logic [ROT_W-1:0] ROT_8  = 5'd8;
  localparam logic [ROT_W-1:0] ROT_7  = 5'd7;

  // idx is the ordinal of the xor-rotate step within the quarter-round (0..3)
  function automatic logic [ROT_W-1:0] rot_for_step(input logic [1:0] idx);
    case (idx)
      2'd0:    return ROT_16;
      2'd1:    return ROT_12;
      2'd2:    return ROT_8;
      default: return ROT_7;
    endcase
  endfunction

endpackage

// File: rtl/chacha_qr_alu.sv
// rtl/chacha_qr_alu.sv - lane-parallel add or xor-rotate-left datapath
module chacha_qr_alu
  import chacha_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [32*LANES-1:0] x,
  input  logic [32*LANES-1:0] y,
  input  logic                op_add,
  input  logic [ROT_W-1:0]    rot,
  output logic [32*LANES-1:0] r
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] xl;
    logic [31:0] yl;
    logic [31:0] mix;

    assign xl  = x[32*i +: 32];
    assign yl  = y[32*i +: 32];
    assign mix = xl ^ yl;
    assign r[32*i +: 32] = op_add ? (xl + yl)
                                  : ((mix << rot) | (mix >> (6'd32 - {1'b0, rot})));
  end

endmodule

// File: rtl/chacha_qr_seq.sv
// rtl/chacha_qr_seq.sv - multi-cycle lane-parallel ChaCha quarter-round engine
// CHACHA_QR_FUSED_EN: run add and xor-rotate pairs in one cycle (4-cycle RUN).
module chacha_qr_seq
  import chacha_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_a,
  input  logic [32*LANES-1:0] in_b,
  input  logic [32*LANES-1:0] in_c,
  input  logic [32*LANES-1:0] in_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_a,
  output logic [32*LANES-1:0] out_b,
  output logic [32*LANES-1:0] out_c,
  output logic [32*LANES-1:0] out_d,
  output logic                busy
);

  localparam int W = 32 * LANES;

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic [W-1:0]      reg_a, reg_b, reg_c, reg_d;
  logic [W-1:0]      nxt_a, nxt_b, nxt_c, nxt_d;
  logic              accept;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);
  assign out_a     = reg_a;
  assign out_b     = reg_b;
  assign out_c     = reg_c;
  assign out_d     = reg_d;

`ifdef CHACHA_QR_FUSED_EN
  logic [W-1:0]       add_x, add_y, add_r, mix_x, mix_r;
  logic [ROT_W-1:0]   mix_rot;

  // odd pairs work on (c,d)->c then (b,c')->b; even pairs on (a,b)->a then (d,a')->d
  assign add_x   = step[0] ? reg_c : reg_a;
  assign add_y   = step[0] ? reg_d : reg_b;
  assign mix_x   = step[0] ? reg_b : reg_d;
  assign mix_rot = rot_for_step(step);

  chacha_qr_alu #(.LANES(LANES)) u_alu_add (
    .x(add_x), .y(add_y), .op_add(1'b1), .rot('0), .r(add_r)
  );

  chacha_qr_alu #(.LANES(LANES)) u_alu_mix (
    .x(mix_x), .y(add_r), .op_add(1'b0), .rot(mix_rot), .r(mix_r)
  );

  always_comb begin
    nxt_a = reg_a;
    nxt_b = reg_b;
    nxt_c = reg_c;
    nxt_d = reg_d;
    if (step[0]) begin
      nxt_c = add_r;
      nxt_b = mix_r;
    end else begin
      nxt_a = add_r;
      nxt_d = mix_r;
    end
  end
`else
  logic [W-1:0]     alu_x, alu_y, alu_r;
  logic [ROT_W-1:0] alu_rot;

  assign alu_rot = rot_for_step(step[2:1]);

  // step[1:0] names the (dest, src) pair; even steps add, odd steps xor-rotate
  always_comb begin
    alu_x = reg_a;
    alu_y = reg_b;
    case (step[1:0])
      2'd1: begin alu_x = reg_d; alu_y = reg_a; end
      2'd2: begin alu_x = reg_c; alu_y = reg_d; end
      2'd3: begin alu_x = reg_b; alu_y = reg_c; end
      default: ;
    endcase
  end

  chacha_qr_alu #(.LANES(LANES)) u_alu (
    .x(alu_x), .y(alu_y), .op_add(~step[0]), .rot(alu_rot), .r(alu_r)
  );

  always_comb begin
    nxt_a = reg_a;
    nxt_b = reg_b;
    nxt_c = reg_c;
    nxt_d = reg_d;
    case (step[1:0])
      2'd0:    nxt_a = alu_r;
      2'd1:    nxt_d = alu_r;
      2'd2:    nxt_c = alu_r;
      default: nxt_b = alu_r;
    endcase
  end
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
      step  <= '0;
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
      reg_d <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            reg_a <= in_a;
            reg_b <= in_b;
            reg_c <= in_c;
            reg_d <= in_d;
            step  <= '0;
            state <= ST_RUN;
          end else if ((state == ST_DONE) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          reg_a <= nxt_a;
          reg_b <= nxt_b;
          reg_c <= nxt_c;
          reg_d <= nxt_d;
          // the counter wraps back to zero on the last step
          step  <= step + STEP_W'(1);
          if (step == '1) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_qr_seq.sv
// tb/tb_chacha_qr_seq.sv - directed and random checks of the quarter-round engine
module tb_chacha_qr_seq;

  localparam int LANES = 2;
  localparam int W     = 32 * LANES;
`ifdef CHACHA_QR_FUSED_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         busy;

  int n_checks = 0;
  int n_fails  = 0;

  // RFC 7539 2.1.1 vector and hand-worked all-ones vector
  localparam logic [31:0] RA = 32'h11111111, RB = 32'h01020304, RC = 32'h9b8d6f43, RD = 32'h01234567;
  localparam logic [31:0] XA = 32'hea2a92f4, XB = 32'hcb1cf8ce, XC = 32'h4581472e, XD = 32'h5881c4bb;
  localparam logic [31:0] ONES = 32'hffffffff;
  localparam logic [31:0] OA = 32'hf0000ffd, OB = 32'h88790878, OC = 32'h0110fdef, OD = 32'h010ffdf0;

  chacha_qr_seq #(.LANES(LANES)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  task automatic wait_result(input string tag, input int start);
    int n;
    n = start;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(LAT));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] ea, eb, ec, ed);
    check({tag, " out_a"}, out_a, ea);
    check({tag, " out_b"}, out_b, eb);
    check({tag, " out_c"}, out_c, ec);
    check({tag, " out_d"}, out_d, ed);
  endtask

  task automatic do_req(input string tag, input logic [W-1:0] a, b, c, d,
                        input logic [W-1:0] ea, eb, ec, ed, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_d = d;
    tick();
    in_valid = 1'b0;
    wait_result(tag, 0);
    check_out(tag, ea, eb, ec, ed);
    repeat (stall) tick();
    check({tag, " held out_a"}, out_a, ea);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " drop out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0]   ra, rb, rc, rd, ea, eb, ec, ed;
    logic [127:0]   q;
    int             n;

    tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check_out("reset", '0, '0, '0, '0);
    g_resetn = 1'b1;
    tick();

    // lane0 RFC vector, lane1 all-ones
    do_req("rfc_lanes", {ONES, RA}, {ONES, RB}, {ONES, RC}, {ONES, RD},
           {OA, XA}, {OB, XB}, {OC, XC}, {OD, XD}, 0);

    // backpressure then back-to-back accept
    in_valid = 1'b1; in_a = {RA, RA}; in_b = {RB, RB}; in_c = {RC, RC}; in_d = {RD, RD};
    tick();
    in_valid = 1'b0;
    check("bp busy", 64'(busy), 64'd1);
    wait_result("bp", 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp stall in_ready", 64'(in_ready), 64'd0);
      check("bp stall out_valid", 64'(out_valid), 64'd1);
      check("bp stall out_d", out_d, {XD, XD});
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = {RA, ONES}; in_b = {RB, ONES}; in_c = {RC, ONES}; in_d = {RD, ONES};
    #1;
    check("bp same-cycle in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp b2b out_valid", 64'(out_valid), 64'd0);
    check("bp b2b busy", 64'(busy), 64'd1);
    wait_result("bp b2b", 0);
    check_out("bp b2b", {XA, OA}, {XB, OB}, {XC, OC}, {XD, OD});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // in_valid during RUN must be ignored
    in_valid = 1'b1; in_a = {RA, RA}; in_b = {RB, RB}; in_c = {RC, RC}; in_d = {RD, RD};
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_a = '1; in_b = '0; in_c = '1; in_d = '0;
    check("ign in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    wait_result("ign", 2);
    check_out("ign", {XA, XA}, {XB, XB}, {XC, XC}, {XD, XD});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset with the step counter at 4 (or mid-RUN in the fused build)
    in_valid = 1'b1; in_a = {RA, RA}; in_b = {RB, RB}; in_c = {RC, RC}; in_d = {RD, RD};
    tick();
    in_valid = 1'b0;
    repeat (LAT / 2) tick();
    g_resetn = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check_out("rst", '0, '0, '0, '0);
    tick();
    g_resetn = 1'b1;
    tick();
    check("rst in_ready", 64'(in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("rst no stray out_valid", 64'(n), 64'd0);
    do_req("post_rst", {RA, RA}, {RB, RB}, {RC, RC}, {RD, RD},
           {XA, XA}, {XB, XB}, {XC, XC}, {XD, XD}, 1);

    for (int k = 0; k < 1000; k++) begin
      for (int l = 0; l < LANES; l++) begin
        ra[32*l +: 32] = $urandom();
        rb[32*l +: 32] = $urandom();
        rc[32*l +: 32] = $urandom();
        rd[32*l +: 32] = $urandom();
        q = qr_ref(ra[32*l +: 32], rb[32*l +: 32], rc[32*l +: 32], rd[32*l +: 32]);
        ea[32*l +: 32] = q[127:96];
        eb[32*l +: 32] = q[95:64];
        ec[32*l +: 32] = q[63:32];
        ed[32*l +: 32] = q[31:0];
      end
      do_req("rand", ra, rb, rc, rd, ea, eb, ec, ed, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
